// File: rtl/fpga_slow_clk_monitor.sv
// Measures a slow FPGA-generated clock against the reference clock and reports
// window measurement, range errors, lock and loss-of-clock status.
module fpga_slow_clk_monitor #(
   parameter int unsigned CNT_WIDTH      = 24,
   parameter int unsigned WINDOW_EDGES   = 4,
   parameter int unsigned EXP_MIN        = 15000,
   parameter int unsigned EXP_MAX        = 15500,
   parameter int unsigned TIMEOUT_CYCLES = 20000,
   parameter int unsigned LOCK_COUNT     = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 slow_clk_i,
   input  logic                 enable_i,
   output logic [CNT_WIDTH-1:0] meas_o,
   output logic                 valid_o,
   output logic                 range_err_o,
   output logic                 locked_o,
   output logic                 dead_o
);

   localparam int unsigned EDGE_W = $clog2(WINDOW_EDGES + 1);
   localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
   localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned CMP_W  = (CNT_WIDTH > 32) ? CNT_WIDTH : 32;

   localparam logic [EDGE_W-1:0]    LAST_EDGE = EDGE_W'(WINDOW_EDGES - 1);
   localparam logic [GOOD_W-1:0]    GOOD_MAX  = GOOD_W'(LOCK_COUNT);
   localparam logic [IDLE_W-1:0]    IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ALL1  = '1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_FIRST,
      MEASURE
   } state_t;

   state_t                state_q, state_d;
   logic                  sync1_q, sync2_q, hist_q;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [EDGE_W-1:0]     edges_q, edges_d;
   logic [IDLE_W-1:0]     idle_q, idle_d;
   logic [GOOD_W-1:0]     good_q, good_d;
   logic [CNT_WIDTH-1:0]  meas_d;
   logic                  valid_d, err_d, locked_d, dead_d;

   logic                  rise_c;
   logic                  timeout_c;
   logic                  in_range_c;
   logic [CNT_WIDTH-1:0]  cnt_inc_c;
   logic [IDLE_W-1:0]     idle_inc_c;
   logic [GOOD_W-1:0]     good_inc_c;

   assign rise_c     = sync2_q & ~hist_q;
   assign cnt_inc_c  = (cnt_q == CNT_ALL1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
   assign idle_inc_c = (idle_q == IDLE_MAX) ? idle_q : idle_q + IDLE_W'(1);
   assign good_inc_c = (good_q == GOOD_MAX) ? good_q : good_q + GOOD_W'(1);
   assign timeout_c  = ~rise_c & (idle_inc_c == IDLE_MAX);
   // A saturated count means the true period is unknown, so it never qualifies.
   assign in_range_c = (cnt_inc_c != CNT_ALL1)
                     && (CMP_W'(cnt_inc_c) >= CMP_W'(EXP_MIN))
                     && (CMP_W'(cnt_inc_c) <= CMP_W'(EXP_MAX));

   // Next-state and output logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      edges_d  = edges_q;
      idle_d   = idle_q;
      good_d   = good_q;
      meas_d   = meas_o;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      locked_d = locked_o;
      dead_d   = dead_o;

      if (!enable_i) begin
         state_d  = IDLE;
         cnt_d    = '0;
         edges_d  = '0;
         idle_d   = '0;
         good_d   = '0;
         locked_d = 1'b0;
         dead_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = WAIT_FIRST;
            end
            WAIT_FIRST: begin
               if (rise_c) begin
                  cnt_d   = '0;
                  edges_d = '0;
                  state_d = MEASURE;
               end
            end
            MEASURE: begin
               cnt_d = cnt_inc_c;
               if (rise_c) begin
                  if (edges_q == LAST_EDGE) begin
                     // Boundary edge closes this window and opens the next.
                     cnt_d   = '0;
                     edges_d = '0;
                     meas_d  = cnt_inc_c;
                     valid_d = 1'b1;
                     if (in_range_c) begin
                        good_d   = good_inc_c;
                        locked_d = (good_inc_c == GOOD_MAX);
                     end else begin
                        good_d   = '0;
                        locked_d = 1'b0;
                        err_d    = 1'b1;
                     end
                  end else begin
                     edges_d = edges_q + EDGE_W'(1);
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         // Loss-of-clock watchdog; a rise in the threshold cycle takes priority.
         if (state_q != IDLE) begin
            if (rise_c) begin
               idle_d = '0;
               dead_d = 1'b0;
            end else if (timeout_c) begin
               idle_d   = idle_inc_c;
               dead_d   = 1'b1;
               locked_d = 1'b0;
               good_d   = '0;
               cnt_d    = '0;
               edges_d  = '0;
               state_d  = WAIT_FIRST;
            end else begin
               idle_d = idle_inc_c;
            end
         end
      end
   end

   // State, synchronizer and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         hist_q      <= 1'b0;
         cnt_q       <= '0;
         edges_q     <= '0;
         idle_q      <= '0;
         good_q      <= '0;
         meas_o      <= '0;
         valid_o     <= 1'b0;
         range_err_o <= 1'b0;
         locked_o    <= 1'b0;
         dead_o      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= slow_clk_i;
         sync2_q     <= sync1_q;
         hist_q      <= sync2_q;
         cnt_q       <= cnt_d;
         edges_q     <= edges_d;
         idle_q      <= idle_d;
         good_q      <= good_d;
         meas_o      <= meas_d;
         valid_o     <= valid_d;
         range_err_o <= err_d;
         locked_o    <= locked_d;
         dead_o      <= dead_d;
      end
   end

endmodule

// File: tb/tb_fpga_slow_clk_monitor.sv
// Bench for fpga_slow_clk_monitor: table of measurement windows checked through
// a scoreboard, plus hand-written clock-loss, abort, reset and saturation cases.
module tb_fpga_slow_clk_monitor;

   typedef struct {
      int p0; int p1; int p2; int p3;
      int meas; bit err; bit lock;
   } vec_t;

   typedef struct {
      int meas; bit err; bit lock;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        slow_a = 1'b0;
   logic        slow_b = 1'b0;
   logic        enable_a = 1'b0;
   logic        enable_b = 1'b0;
   logic [23:0] meas_a;
   logic        valid_a, err_a, locked_a, dead_a;
   logic [5:0]  meas_b;
   logic        valid_b, err_b, locked_b, dead_b;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   prev_valid_cyc = -1;
   int   last_valid_cyc = -1;
   int   sat_valid_cnt = 0;
   int   sat_meas = 0;
   int   sat_err = 0;
   exp_t sb[$];
   vec_t vecs [12];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fpga_slow_clk_monitor #(
      .CNT_WIDTH(24), .WINDOW_EDGES(4), .EXP_MIN(76), .EXP_MAX(84),
      .TIMEOUT_CYCLES(64), .LOCK_COUNT(2)
   ) dut (
      .clk_i(clk), .rst_i(rst), .slow_clk_i(slow_a), .enable_i(enable_a),
      .meas_o(meas_a), .valid_o(valid_a), .range_err_o(err_a),
      .locked_o(locked_a), .dead_o(dead_a)
   );

   // 6-bit counter: a 160-cycle window must clamp at 63 even though 63 <= EXP_MAX.
   fpga_slow_clk_monitor #(
      .CNT_WIDTH(6), .WINDOW_EDGES(4), .EXP_MIN(50), .EXP_MAX(63),
      .TIMEOUT_CYCLES(128), .LOCK_COUNT(2)
   ) dut_sat (
      .clk_i(clk), .rst_i(rst), .slow_clk_i(slow_b), .enable_i(enable_b),
      .meas_o(meas_b), .valid_o(valid_b), .range_err_o(err_b),
      .locked_o(locked_b), .dead_o(dead_b)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One slow period starting with a rising edge; sel 0 drives dut, 1 drives dut_sat.
   task automatic slow_period(input int sel, input int p);
      if (sel == 0) slow_a = 1'b1; else slow_b = 1'b1;
      step(p / 2);
      if (sel == 0) slow_a = 1'b0; else slow_b = 1'b0;
      step(p - p / 2);
   endtask

   task automatic push_exp(input int meas, input bit err, input bit lock);
      exp_t e;
      e.meas = meas; e.err = err; e.lock = lock;
      sb.push_back(e);
   endtask

   task automatic drive_window(input int p0, input int p1, input int p2, input int p3,
                               input int meas, input bit err, input bit lock);
      slow_period(0, p0);
      slow_period(0, p1);
      slow_period(0, p2);
      slow_period(0, p3);
      // Result appears after the next rising edge, which the caller drives.
      push_exp(meas, err, lock);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (valid_a) begin
            if (sb.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               check("meas", int'(meas_a), e.meas);
               check("range_err", int'(err_a), int'(e.err));
               check("locked", int'(locked_a), int'(e.lock));
               if (prev_valid_cyc >= 0)
                  check("valid_gap", cyc - prev_valid_cyc, e.meas);
            end
            prev_valid_cyc = cyc;
            last_valid_cyc = cyc;
         end else if (err_a) begin
            check("err_without_valid", 1, 0);
         end
         if (valid_b) begin
            sat_valid_cnt++;
            sat_meas = int'(meas_b);
            sat_err  = int'(err_b);
         end
      end
   endtask

   initial begin
      int k;
      int k2;
      vecs[0]  = '{20, 20, 20, 20,  80, 1'b0, 1'b0};
      vecs[1]  = '{20, 20, 20, 20,  80, 1'b0, 1'b1};
      vecs[2]  = '{25, 25, 25, 25, 100, 1'b1, 1'b0};
      vecs[3]  = '{20, 20, 20, 20,  80, 1'b0, 1'b0};
      vecs[4]  = '{20, 20, 20, 20,  80, 1'b0, 1'b1};
      vecs[5]  = '{19, 19, 19, 19,  76, 1'b0, 1'b1};
      vecs[6]  = '{21, 21, 21, 21,  84, 1'b0, 1'b1};
      vecs[7]  = '{19, 19, 19, 18,  75, 1'b1, 1'b0};
      vecs[8]  = '{20, 20, 20, 20,  80, 1'b0, 1'b0};
      vecs[9]  = '{21, 21, 21, 22,  85, 1'b1, 1'b0};
      vecs[10] = '{20, 20, 20, 20,  80, 1'b0, 1'b0};
      vecs[11] = '{20, 20, 20, 20,  80, 1'b0, 1'b1};

      fork
         monitor();
      join_none

      step(3);
      rst = 1'b0;
      step(1);
      check("reset_meas", int'(meas_a), 0);
      check("reset_valid", int'(valid_a), 0);
      check("reset_err", int'(err_a), 0);
      check("reset_locked", int'(locked_a), 0);
      check("reset_dead", int'(dead_a), 0);

      enable_a = 1'b1;
      step(2);
      for (int i = 0; i < 12; i++)
         drive_window(vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3,
                      vecs[i].meas, vecs[i].err, vecs[i].lock);

      // Closing edge, then the slow clock stops; edge at cycle k is a rise at k+2.
      k = cyc;
      slow_a = 1'b1;
      step(10);
      slow_a = 1'b0;
      step(55);
      check("dead_before_timeout", int'(dead_a), 0);
      check("locked_before_timeout", int'(locked_a), 1);
      step(1);
      check("dead_at_timeout", int'(dead_a), 1);
      check("locked_at_timeout", int'(locked_a), 0);
      check("dead_edge_cycle", cyc - k, 66);
      step(34);
      check("dead_held", int'(dead_a), 1);

      // Restart: dead clears one cycle after the first rise.
      prev_valid_cyc = -1;
      k2 = cyc;
      slow_a = 1'b1;
      step(2);
      check("dead_at_restart_rise", int'(dead_a), 1);
      step(1);
      check("dead_cleared", int'(dead_a), 0);
      step(7);
      slow_a = 1'b0;
      step(10);
      slow_period(0, 20);
      slow_period(0, 20);
      slow_period(0, 20);
      push_exp(80, 1'b0, 1'b0);
      slow_period(0, 20);
      check("restart_valid_cycle", last_valid_cyc, k2 + 83);
      slow_period(0, 20);
      slow_period(0, 20);
      slow_period(0, 20);
      push_exp(80, 1'b0, 1'b1);

      // Abort halfway through the next window.
      slow_period(0, 20);
      slow_period(0, 20);
      check("locked_before_abort", int'(locked_a), 1);
      enable_a = 1'b0;
      step(1);
      check("abort_locked", int'(locked_a), 0);
      check("abort_dead", int'(dead_a), 0);
      check("abort_meas", int'(meas_a), 80);
      for (int i = 0; i < 4; i++) slow_period(0, 20);
      check("abort_meas_held", int'(meas_a), 80);
      check("abort_no_pending", sb.size(), 0);

      // Re-enable, lock, then reset mid-window.
      enable_a = 1'b1;
      prev_valid_cyc = -1;
      step(2);
      drive_window(20, 20, 20, 20, 80, 1'b0, 1'b0);
      drive_window(20, 20, 20, 20, 80, 1'b0, 1'b1);
      slow_period(0, 20);
      slow_period(0, 20);
      check("locked_before_reset", int'(locked_a), 1);
      check("meas_before_reset", int'(meas_a), 80);
      rst = 1'b1;
      step(1);
      check("midreset_meas", int'(meas_a), 0);
      check("midreset_valid", int'(valid_a), 0);
      check("midreset_err", int'(err_a), 0);
      check("midreset_locked", int'(locked_a), 0);
      check("midreset_dead", int'(dead_a), 0);
      rst = 1'b0;
      prev_valid_cyc = -1;

      // Saturation on the narrow instance: 4 x 40 cycles clamps at 63.
      enable_b = 1'b1;
      step(2);
      for (int i = 0; i < 4; i++) slow_period(1, 40);
      slow_period(1, 40);
      check("sat_valid_count", sat_valid_cnt, 1);
      check("sat_meas", sat_meas, 63);
      check("sat_range_err", sat_err, 1);
      check("sat_locked", int'(locked_b), 0);
      check("sat_dead", int'(dead_b), 0);

      check("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
